gf2_digit_mul: RTL and testbench

Digit-serial binary-polynomial (carry-less, GF(2)[x]) multiplier producing the full unreduced product of an AW-bit operand and a BW-bit operand. It replaces fixed shift-and-XOR recombination stages with one iterative engine. Each cycle it folds one DW-bit digit of B into an accumulator, Horner-style. It sits in the ECC field-multiplication path ahead of modular reduction, with valid/ready handshakes on both sides.

---
 rtl/gf2_pkg.sv | 45 ++++
 rtl/gf2_clmul_row.sv | 23 ++
 rtl/gf2_digit_mul.sv | 127 ++++++++++++
 tb/tb_gf2_digit_mul.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_pkg.sv
// gf2_pkg: definitions shared by the digit-serial GF(2)[x] multiplier.
//   state_t          - engine FSM states (IDLE, RUN, DONE)
//   gf2_pw/gf2_nb    - product width and number of B digits (ceil-div)
//   gf2_jw           - digit counter width (at least one bit)
//   gf2_clmul_digit  - carry-less product of an operand and one digit,
//                      computed on GF2_MAXW-bit containers so that any
//                      AW, DW up to GF2_MAXW can use it via zero-extension.
package gf2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Widest operand/digit the row function supports.
  localparam int GF2_MAXW = 256;

  function automatic int gf2_pw(input int aw, input int bw);
    return aw + bw - 1;
  endfunction

  function automatic int gf2_nb(input int bw, input int dw);
    return (bw + dw - 1) / dw;
  endfunction

  function automatic int gf2_jw(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  // XOR of (d[k] ? a << k : 0) over all k. Zero digit bits contribute
  // nothing, so the unused upper part of the containers folds away.
  function automatic logic [2*GF2_MAXW-1:0] gf2_clmul_digit(
    input logic [GF2_MAXW-1:0] a,
    input logic [GF2_MAXW-1:0] d
  );
    logic [2*GF2_MAXW-1:0] r;
    r = '0;
    for (int k = 0; k < GF2_MAXW; k++) begin
      if (d[k]) r ^= {{GF2_MAXW{1'b0}}, a} << k;
    end
    return r;
  endfunction

endpackage

// File: rtl/gf2_clmul_row.sv
// gf2_clmul_row: combinational AW x DW carry-less row product.
// Ports:
//   a  in  AW        operand A
//   d  in  DW        one digit of operand B
//   p  out AW+DW-1   a * d over GF(2)[x]
// AW and DW must not exceed gf2_pkg::GF2_MAXW.
module gf2_clmul_row
  import gf2_pkg::*;
#(
  parameter int AW = 194,
  parameter int DW = 8
) (
  input  logic [AW-1:0]    a,
  input  logic [DW-1:0]    d,
  output logic [AW+DW-2:0] p
);

  localparam int RW = AW + DW - 1;

  // The true degree is below AW+DW-1, so the truncation drops only zeros.
  assign p = RW'(gf2_clmul_digit(GF2_MAXW'(a), GF2_MAXW'(d)));

endmodule

// File: rtl/gf2_digit_mul.sv
// gf2_digit_mul: digit-serial carry-less multiplier, full unreduced
// product c = a * b over GF(2)[x]. One DW-bit digit of B is folded into
// the accumulator per cycle, most significant digit first (Horner).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (ready only when idle)
//   a [AW], b [BW]      operands
//   acc_mode            XOR the new product into the previous c
//                       (present only when GF2MUL_ACC_EN is defined)
//   out_valid/out_ready result handshake
//   c [AW+BW-1]         product register, held until the next result
// Optional feature macro: GF2MUL_ACC_EN.
module gf2_digit_mul
  import gf2_pkg::*;
#(
  parameter int AW = 194,
  parameter int BW = 171,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     a,
  input  logic [BW-1:0]     b,
`ifdef GF2MUL_ACC_EN
  input  logic              acc_mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW+BW-2:0]  c
);

  localparam int PW  = gf2_pw(AW, BW);
  localparam int NB  = gf2_nb(BW, DW);
  localparam int JW  = gf2_jw(NB);
  localparam int BPW = NB * DW;
  localparam int RW  = AW + DW - 1;

  state_t          state;
  logic [AW-1:0]   a_r;
  logic [BPW-1:0]  b_r;     // zero-padded B; top digit is always the next one
  logic [PW-1:0]   prod;
  logic [PW-1:0]   prod_next;
  logic [JW-1:0]   j;
  logic [RW-1:0]   row;
`ifdef GF2MUL_ACC_EN
  logic            acc_r;
`endif

  gf2_clmul_row #(
    .AW (AW),
    .DW (DW)
  ) u_row (
    .a (a_r),
    .d (b_r[BPW-1 -: DW]),
    .p (row)
  );

  // Shifting left by DW can only drop zeros: the degree stays below
  // AW plus the number of B bits processed so far.
  assign prod_next = (prod << DW) ^ PW'(row);

  // NOTE: operand registers carry no reset; they are always loaded at
  // acceptance before being read, so resetting them would only add logic.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_r   <= a;
      b_r   <= BPW'(b);
`ifdef GF2MUL_ACC_EN
      acc_r <= acc_mode;
`endif
    end else if (state == RUN) begin
      b_r <= b_r << DW;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      prod      <= '0;
      j         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            prod     <= '0;
            j        <= JW'(NB - 1);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          prod <= prod_next;
          j    <= j - 1'b1;
          if (j == '0) begin
`ifdef GF2MUL_ACC_EN
            c <= prod_next ^ (acc_r ? c : '0);
`else
            c <= prod_next;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_digit_mul.sv
// tb_gf2_digit_mul: scoreboard bench for gf2_digit_mul. Three instances
// (DW = 1, 8, 171) share operands and handshake inputs; each has its own
// expected-result and issue-cycle queues checked by a negedge monitor.
module tb_gf2_digit_mul;

  localparam int AW = 194;
  localparam int BW = 171;
  localparam int PW = AW + BW - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic [AW-1:0] a;
  logic [BW-1:0] b;
`ifdef GF2MUL_ACC_EN
  logic          acc_mode;
`endif

  logic          rdy [3];
  logic          ov  [3];
  logic [PW-1:0] cc  [3];

  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [PW-1:0] exp_q [3][$];
  int            iss_q [3][$];
  logic [PW-1:0] c_model;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] clmul_ref(input logic [AW-1:0] x,
                                              input logic [BW-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < BW; i++) begin
      if (y[i]) r ^= PW'(x) << i;
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dw
    localparam int DWI = (gi == 0) ? 1 : ((gi == 1) ? 8 : 171);
    localparam int NBI = (BW + DWI - 1) / DWI;
    logic          rdy_i;
    logic          ov_i;
    logic [PW-1:0] c_i;
    logic          ov_prev = 1'b0;
    int            t;

    gf2_digit_mul #(
      .AW (AW),
      .BW (BW),
      .DW (DWI)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy_i),
      .a         (a),
      .b         (b),
`ifdef GF2MUL_ACC_EN
      .acc_mode  (acc_mode),
`endif
      .out_valid (ov_i),
      .out_ready (out_ready),
      .c         (c_i)
    );

    assign rdy[gi] = rdy_i;
    assign ov[gi]  = ov_i;
    assign cc[gi]  = c_i;

    always @(negedge clk) begin
      if (rst_n) begin
        if (ov_i && !ov_prev) begin
          if (iss_q[gi].size() == 0) begin
            check($sformatf("spurious_valid_dw%0d", DWI), PW'(ov_i), '0);
          end else begin
            t = iss_q[gi].pop_front();
            check($sformatf("latency_dw%0d", DWI), PW'(cyc - t), PW'(NBI + 1));
          end
        end
        if (ov_i && out_ready) begin
          if (exp_q[gi].size() == 0) begin
            check($sformatf("spurious_result_dw%0d", DWI), PW'(ov_i), '0);
          end else begin
            check($sformatf("result_dw%0d", DWI), c_i, exp_q[gi].pop_front());
          end
        end
      end
      ov_prev = ov_i;
    end
  end

  task automatic issue(input logic [AW-1:0] av, input logic [BW-1:0] bv,
                       input logic accv, input logic [PW-1:0] prodv);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check("issue_wait", PW'({rdy[0], rdy[1], rdy[2]}), PW'(3'b111));
      return;
    end
    a        = av;
    b        = bv;
    in_valid = 1'b1;
`ifdef GF2MUL_ACC_EN
    acc_mode = accv;
    c_model  = accv ? (c_model ^ prodv) : prodv;
`else
    c_model  = prodv;
`endif
    for (int i = 0; i < 3; i++) begin
      exp_q[i].push_back(c_model);
      iss_q[i].push_back(cyc);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000)
      check("drain", PW'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), '0);
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      iss_q[i].delete();
    end
    c_model = '0;
  endtask

  initial begin
    logic [AW-1:0] av;
    logic [BW-1:0] bv;
    logic [PW-1:0] ev;
    int            n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
`ifdef GF2MUL_ACC_EN
    acc_mode  = 1'b0;
`endif
    c_model   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_in_ready_%0d", i), PW'(rdy[i]), PW'(1));
      check($sformatf("rst_out_valid_%0d", i), PW'(ov[i]), '0);
      check($sformatf("rst_c_%0d", i), cc[i], '0);
    end

`ifdef GF2MUL_ACC_EN
    // Accumulating into the reset value of c gives the plain product.
    issue(AW'(3), BW'(3), 1'b1, PW'(5));
    drain();
`endif

    // Directed vectors with hand-derived products.
    issue(AW'(1), BW'(1), 1'b0, PW'(1));
    av = '0; av[193] = 1'b1;
    bv = '0; bv[170] = 1'b1;
    ev = '0; ev[363] = 1'b1;
    issue(av, bv, 1'b0, ev);
    av = '1;
    ev = '0; ev[AW-1:0] = '1;
    issue(av, BW'(1), 1'b0, ev);
    ev = '0; ev[0] = 1'b1; ev[194] = 1'b1;          // (x+1) * sum x^i
    issue(av, BW'(3), 1'b0, ev);
    issue(AW'(8'hFF), BW'(8'hFF), 1'b0, PW'(16'h5555));
    bv = '1;
    issue(AW'(1), bv, 1'b0, PW'(bv));
    issue('0, bv, 1'b0, '0);
    av = '0; av[193] = 1'b1; av[0] = 1'b1;
    bv = '0; bv[170] = 1'b1; bv[0] = 1'b1;
    ev = '0; ev[363] = 1'b1; ev[193] = 1'b1; ev[170] = 1'b1; ev[0] = 1'b1;
    issue(av, bv, 1'b0, ev);

`ifdef GF2MUL_ACC_EN
    issue(AW'(3), BW'(3), 1'b0, PW'(5));
    issue(AW'(1), BW'(1), 1'b1, PW'(1));            // 5 ^ 1 = 4
`endif

    // Mixed operands against a bitwise shift-and-XOR reference.
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < AW; k++) av[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < BW; k++) bv[k] = 1'($urandom_range(0, 1));
      issue(av, bv, 1'b0, clmul_ref(av, bv));
    end
    drain();

    // Back-pressure: hold DONE, junk in_valid pulses must be ignored.
    out_ready = 1'b0;
    issue(AW'(32), BW'(8'hA5), 1'b0, PW'(16'h14A0));
    n = 0;
    while (!ov[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("stall_reach_done", PW'(ov[1]), PW'(1));
    for (int s = 0; s < 10; s++) begin
      if (s == 2 || s == 6) begin
        a = AW'(7); b = BW'(7); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("stall_c", cc[1], PW'(16'h14A0));
      check("stall_out_valid", PW'(ov[1]), PW'(1));
      check("stall_in_ready", PW'(rdy[1]), '0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    issue(AW'(5), BW'(5), 1'b0, PW'(8'h11));
    drain();

    // Reset in the middle of a multiply discards it.
    issue(AW'(1), BW'(1), 1'b0, PW'(1));
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    clear_queues();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midrst_in_ready_%0d", i), PW'(rdy[i]), PW'(1));
      check($sformatf("midrst_out_valid_%0d", i), PW'(ov[i]), '0);
      check($sformatf("midrst_c_%0d", i), cc[i], '0);
    end
    @(negedge clk);
    check("midrst_out_valid_hold", PW'(ov[1]), '0);
    issue(AW'(6), BW'(3), 1'b0, PW'(4'hA));       // (x^2+x)(x+1) = x^3+x
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
